// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_pkg
// Description : Shared types and constants for the multi-cycle data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LAT_CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_e;

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_array
// Description : Word array with synchronous write and registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Contents and read register are intentionally never reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= mem_q[i_addr];
        end
    end

endmodule : data_mem_array
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Multi-cycle MEM-stage data memory with pipeline stall output.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        mem_stall,
    output logic        misaligned_err,
    output logic        range_err,
    output logic [15:0] access_count
);

    localparam int c_addr_w     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int c_byte_off_w = $clog2(WORD_BYTES);
    localparam logic [LAT_CNT_W-1:0] c_lat_load = LAT_CNT_W'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
            $error("data_mem_responder: LATENCY must be in 1..15");
        end
    endgenerate

    state_e                state_q, state_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [c_addr_w-1:0]   addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  is_write_q, is_write_d;
    logic                  in_range_q, in_range_d;
    logic                  mis_q, mis_d;
    logic                  rng_q, rng_d;
    logic [15:0]           count_q, count_d;
    logic                  rd_zero_q, rd_zero_d;

    logic                  w_req;
    logic [31-c_byte_off_w:0] w_word_idx;
    logic                  w_in_range;
    logic                  w_we;
    logic                  w_re;
    logic                  w_stall;
    logic [31:0]           w_arr_rdata;

    assign w_req      = MemRead | MemWrite;
    assign w_word_idx = Address[31:c_byte_off_w];
    assign w_in_range = ({{c_byte_off_w{1'b0}}, w_word_idx} < 32'($unsigned(DEPTH_WORDS)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        in_range_d = in_range_q;
        mis_d      = mis_q;
        rng_d      = rng_q;
        count_d    = count_q;
        rd_zero_d  = rd_zero_q;
        w_we       = 1'b0;
        w_re       = 1'b0;
        w_stall    = 1'b0;
        case (state_q)
            S_IDLE: begin
                w_stall = w_req;
                if (w_req) begin
                    addr_d     = w_word_idx[c_addr_w-1:0];
                    wdata_d    = WriteData;
                    is_write_d = MemWrite;
                    in_range_d = w_in_range;
                    mis_d      = mis_q | (Address[c_byte_off_w-1:0] != '0);
                    rng_d      = rng_q | ~w_in_range;
                    cnt_d      = c_lat_load;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (!w_req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_RESPOND;
                    if (is_write_q) begin
                        w_we = in_range_q;
                    end else begin
                        w_re      = in_range_q;
                        rd_zero_d = ~in_range_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // rd_zero_q masks the unreset array read register after reset and on out-of-range reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            in_range_q <= 1'b0;
            mis_q      <= 1'b0;
            rng_q      <= 1'b0;
            count_q    <= '0;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            in_range_q <= in_range_d;
            mis_q      <= mis_d;
            rng_q      <= rng_d;
            count_q    <= count_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (c_addr_w)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we & rst_n),
        .i_re    (w_re & rst_n),
        .i_addr  (addr_q),
        .i_wdata (wdata_q),
        .o_rdata (w_arr_rdata)
    );

    assign ReadData       = rd_zero_q ? 32'h0 : w_arr_rdata;
    assign mem_stall      = w_stall & rst_n;
    assign misaligned_err = mis_q;
    assign range_err      = rng_q;
    assign access_count   = count_q;

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Scoreboard bench for the multi-cycle data memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        mem_stall;
    logic        misaligned_err;
    logic        range_err;
    logic [15:0] access_count;

    int          n_checks = 0;
    int          n_pass   = 0;

    logic [31:0] model_mem [int];
    logic [31:0] rd_q [$];
    logic [31:0] last_rd;
    logic [15:0] exp_count;
    logic        exp_mis;
    logic        exp_rng;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .Address        (Address),
        .WriteData      (WriteData),
        .ReadData       (ReadData),
        .mem_stall      (mem_stall),
        .misaligned_err (misaligned_err),
        .range_err      (range_err),
        .access_count   (access_count)
    );

    always #5 clk = ~clk;

    task automatic clear_model();
        exp_count = 16'd0;
        exp_mis   = 1'b0;
        exp_rng   = 1'b0;
        last_rd   = 32'h0;
        rd_q.delete();
    endtask

    // Entered just after a rising edge; returns just after the edge that leaves RESPOND.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d);
        int          stalls;
        bit          done;
        logic [29:0] idx;
        logic [31:0] exp_rd;
        idx    = a[31:2];
        stalls = 0;
        done   = 1'b0;
        if (a[1:0] != 2'b00) exp_mis = 1'b1;
        if (int'(idx) >= DEPTH) exp_rng = 1'b1;
        if (!wr) begin
            exp_rd = (int'(idx) < DEPTH) ? model_mem[int'(idx)] : 32'h0;
            rd_q.push_back(exp_rd);
        end
        MemRead   = rd;
        MemWrite  = wr;
        Address   = a;
        WriteData = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (mem_stall) begin
                stalls++;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        n_checks++;
        if (!done) begin
            $display("FAIL access_timeout addr=%h: stall never released within 40 cycles", a);
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            if (!wr) void'(rd_q.pop_back());
            return;
        end
        n_pass++;
        n_checks++;
        if (stalls !== LAT + 1)
            $display("FAIL stall_cycles addr=%h: got %0d, want %0d", a, stalls, LAT + 1);
        else n_pass++;
        if (!wr) last_rd = rd_q.pop_front();
        n_checks++;
        if (ReadData !== last_rd)
            $display("FAIL read_data addr=%h wr=%0b: got %h, want %h", a, wr, ReadData, last_rd);
        else n_pass++;
        n_checks++;
        if ({misaligned_err, range_err} !== {exp_mis, exp_rng})
            $display("FAIL err_flags addr=%h: got mis=%0b rng=%0b, want mis=%0b rng=%0b",
                     a, misaligned_err, range_err, exp_mis, exp_rng);
        else n_pass++;
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if (wr && int'(idx) < DEPTH) model_mem[int'(idx)] = d;
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        n_checks++;
        if (access_count !== exp_count)
            $display("FAIL access_count addr=%h: got %0d, want %0d", a, access_count, exp_count);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Address  = 32'h0;
        WriteData = 32'h0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ReadData !== 32'h0) $display("FAIL reset_rdata: got %h, want 0", ReadData);
        else n_pass++;
        n_checks++;
        if (mem_stall !== 1'b0) $display("FAIL reset_stall: got %b, want 0", mem_stall);
        else n_pass++;
        n_checks++;
        if ({misaligned_err, range_err} !== 2'b00)
            $display("FAIL reset_errs: got %b%b, want 00", misaligned_err, range_err);
        else n_pass++;
        n_checks++;
        if (access_count !== 16'd0) $display("FAIL reset_count: got %0d, want 0", access_count);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        do_access(1'b1, 1'b0, 32'h10, 32'h0);
    endtask

    task automatic test_flush(input logic wr, input logic [31:0] a);
        MemRead  = ~wr;
        MemWrite = wr;
        Address  = a;
        WriteData = 32'h0BAD0BAD;
        @(negedge clk);
        n_checks++;
        if (mem_stall !== 1'b1) $display("FAIL flush_stall_start: got %b, want 1", mem_stall);
        else n_pass++;
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (mem_stall !== 1'b0) $display("FAIL flush_stall_end: got %b, want 0", mem_stall);
        else n_pass++;
        n_checks++;
        if (access_count !== exp_count)
            $display("FAIL flush_count: got %0d, want %0d", access_count, exp_count);
        else n_pass++;
        @(posedge clk);
        #1;
        do_access(1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic test_errors();
        do_access(1'b0, 1'b1, 32'h13, 32'hCAFEF00D);
        do_access(1'b1, 1'b0, 32'h10, 32'h0);
        do_access(1'b1, 1'b0, 32'h400, 32'h0);
        do_access(1'b0, 1'b1, 32'h404, 32'h55555555);
        do_access(1'b1, 1'b0, 32'h10, 32'h0);
    endtask

    task automatic test_both_strobes();
        do_access(1'b1, 1'b1, 32'h20, 32'h00001234);
        do_access(1'b1, 1'b0, 32'h20, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 6; i++) begin
            a = 32'($urandom_range(0, 15)) << 2;
            do_access(1'b0, 1'b1, a, $urandom);
            do_access(1'b1, 1'b0, a, 32'h0);
        end
    endtask

    task automatic test_reset_mid_access();
        do_access(1'b0, 1'b1, 32'h8, 32'h0000AAAA);
        MemWrite  = 1'b1;
        Address   = 32'h8;
        WriteData = 32'h0000BBBB;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_stall !== 1'b0) $display("FAIL reset_mid_stall: got %b, want 0", mem_stall);
        else n_pass++;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        n_checks++;
        if ({ReadData, access_count, misaligned_err, range_err} !== {32'h0, 16'd0, 2'b00})
            $display("FAIL reset_mid_state: got rdata=%h cnt=%0d err=%b%b, want 0/0/00",
                     ReadData, access_count, misaligned_err, range_err);
        else n_pass++;
        @(posedge clk);
        #1;
        do_access(1'b1, 1'b0, 32'h8, 32'h0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_flush(1'b0, 32'h10);
        test_flush(1'b1, 32'h10);
        test_errors();
        test_both_strobes();
        test_back_to_back();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_data_mem_responder
`default_nettype wire
